// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared counter encodings and FSM state codes for the branch predictor
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bp_ctr_e;

    typedef enum logic {
        BP_CLEAR = 1'b0,
        BP_IDLE  = 1'b1
    } bp_state_e;

    // Freshly allocated entries start weakly taken.
    localparam bp_ctr_e BP_CTR_ALLOC = WEAK_T;

    function automatic logic ctr_predicts_taken(input bp_ctr_e ctr);
        return ctr[1];
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - combinational 2-bit saturating increment/decrement
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  bp_ctr_e ctr,
    input  logic    taken,
    output bp_ctr_e ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != STRONG_T) begin
                ctr_next = bp_ctr_e'(ctr + 2'd1);
            end
        end else begin
            if (ctr != STRONG_NT) begin
                ctr_next = bp_ctr_e'(ctr - 2'd1);
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped 2-bit counter branch predictor with sweep invalidation and statistics
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int XLEN       = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [XLEN-1:0]      if_pc,
    output logic                 branch_estimation,
    output logic [XLEN-1:0]      predicted_target,
    input  logic                 ex_branch,
    input  logic [XLEN-1:0]      ex_pc,
    input  logic                 ex_taken,
    input  logic [XLEN-1:0]      ex_target,
    input  logic                 ex_prediction_miss,
    input  logic                 flush_req,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    localparam int ENTRIES  = 2 ** INDEX_BITS;
    localparam int TAG_BITS = XLEN - INDEX_BITS - 2;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    bp_ctr_e             ctr_q    [ENTRIES];

    bp_state_e            state_q, state_d;
    logic [INDEX_BITS-1:0] clr_idx_q, clr_idx_d;
    logic [CNT_WIDTH-1:0]  branch_count_q, branch_count_d;
    logic [CNT_WIDTH-1:0]  miss_count_q, miss_count_d;

    logic [INDEX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_BITS-1:0]   if_tag, ex_tag;
    logic                  if_hit, ex_hit;
    bp_ctr_e               ex_ctr, ex_ctr_next;

    logic                  valid_we;
    logic [INDEX_BITS-1:0] valid_widx;
    logic                  valid_wdata;
    logic                  entry_we;
    logic [XLEN-1:0]       entry_target;
    bp_ctr_e               entry_ctr;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    assign if_idx = if_pc[INDEX_BITS+1:2];
    assign if_tag = if_pc[XLEN-1:INDEX_BITS+2];
    assign ex_idx = ex_pc[INDEX_BITS+1:2];
    assign ex_tag = ex_pc[XLEN-1:INDEX_BITS+2];

    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign ex_ctr = ctr_q[ex_idx];

    assign busy              = (state_q == BP_CLEAR);
    assign branch_estimation = !busy && if_hit && ctr_predicts_taken(ctr_q[if_idx]);
    assign predicted_target  = branch_estimation ? target_q[if_idx] : '0;
    assign branch_count      = branch_count_q;
    assign miss_count        = miss_count_q;

    bp_sat_counter u_sat_counter (
        .ctr      (ex_ctr),
        .taken    (ex_taken),
        .ctr_next (ex_ctr_next)
    );

    always_comb begin
        state_d        = state_q;
        clr_idx_d      = clr_idx_q;
        branch_count_d = branch_count_q;
        miss_count_d   = miss_count_q;
        valid_we       = 1'b0;
        valid_widx     = clr_idx_q;
        valid_wdata    = 1'b0;
        entry_we       = 1'b0;
        entry_target   = target_q[ex_idx];
        entry_ctr      = ex_ctr_next;

        case (state_q)
            BP_CLEAR: begin
                valid_we = 1'b1;
                if (flush_req) begin
                    clr_idx_d = '0;
                end else if (clr_idx_q == '1) begin
                    state_d   = BP_IDLE;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            BP_IDLE: begin
                if (flush_req) begin
                    state_d   = BP_CLEAR;
                    clr_idx_d = '0;
                end else if (ex_branch) begin
                    if (branch_count_q != '1) begin
                        branch_count_d = branch_count_q + CNT_WIDTH'(1);
                    end
                    if (ex_prediction_miss && (miss_count_q != '1)) begin
                        miss_count_d = miss_count_q + CNT_WIDTH'(1);
                    end
                    if (ex_hit) begin
                        entry_we = 1'b1;
                        if (ex_taken) begin
                            entry_target = ex_target;
                        end
                    end else if (ex_taken) begin
                        // Allocation overwrites whatever entry aliases to this index.
                        entry_we     = 1'b1;
                        valid_we     = 1'b1;
                        valid_widx   = ex_idx;
                        valid_wdata  = 1'b1;
                        entry_target = ex_target;
                        entry_ctr    = BP_CTR_ALLOC;
                    end
                end
            end
            default: begin
                state_d   = BP_CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= BP_CLEAR;
            clr_idx_q      <= '0;
            branch_count_q <= '0;
            miss_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            clr_idx_q      <= clr_idx_d;
            branch_count_q <= branch_count_d;
            miss_count_q   <= miss_count_d;
        end
    end

    // Table storage carries no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (valid_we) begin
            valid_q[valid_widx] <= valid_wdata;
        end
        if (entry_we) begin
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= entry_target;
            ctr_q[ex_idx]    <= entry_ctr;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] if_pc;
    logic        branch_estimation;
    logic [31:0] predicted_target;
    logic        ex_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_prediction_miss;
    logic        flush_req;
    logic        busy;
    logic [3:0]  branch_count;
    logic [3:0]  miss_count;

    always #5 clk = ~clk;

    branch_predictor #(
        .INDEX_BITS (4),
        .XLEN       (32),
        .CNT_WIDTH  (4)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .if_pc              (if_pc),
        .branch_estimation  (branch_estimation),
        .predicted_target   (predicted_target),
        .ex_branch          (ex_branch),
        .ex_pc              (ex_pc),
        .ex_taken           (ex_taken),
        .ex_target          (ex_target),
        .ex_prediction_miss (ex_prediction_miss),
        .flush_req          (flush_req),
        .busy               (busy),
        .branch_count       (branch_count),
        .miss_count         (miss_count)
    );

    typedef struct {
        int          id;
        int          cyc;
        logic        busy;
        logic        est;
        logic [31:0] tgt;
        logic [3:0]  bc;
        logic [3:0]  mc;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         step_id = 0;
    logic [3:0] m_bc = 4'h0;
    logic [3:0] m_mc = 4'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int id, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, id, got, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            if (mon_e.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL stale step %0d: sampled cycle %0d expected cycle %0d", mon_e.id, cyc, mon_e.cyc);
            end else begin
                chk("busy",   mon_e.id, {31'd0, busy},              {31'd0, mon_e.busy});
                chk("est",    mon_e.id, {31'd0, branch_estimation}, {31'd0, mon_e.est});
                chk("target", mon_e.id, predicted_target,           mon_e.tgt);
                chk("bcount", mon_e.id, {28'd0, branch_count},      {28'd0, mon_e.bc});
                chk("mcount", mon_e.id, {28'd0, miss_count},        {28'd0, mon_e.mc});
            end
        end
    end

    task automatic step(input logic [31:0] ipc, input logic exb, input logic [31:0] epc,
                        input logic tk, input logic [31:0] etg, input logic ms, input logic fl,
                        input logic e_busy, input logic e_est, input logic [31:0] e_tgt);
        exp_t e;
        if_pc              = ipc;
        ex_branch          = exb;
        ex_pc              = epc;
        ex_taken           = tk;
        ex_target          = etg;
        ex_prediction_miss = ms;
        flush_req          = fl;
        e.id   = step_id;
        e.cyc  = cyc;
        e.busy = e_busy;
        e.est  = e_est;
        e.tgt  = e_tgt;
        e.bc   = m_bc;
        e.mc   = m_mc;
        sb_q.push_back(e);
        step_id++;
        @(posedge clk);
        #1;
        if (exb && !e_busy && !fl && reset_n) begin
            if (m_bc != 4'hF) m_bc = m_bc + 4'h1;
            if (ms && m_mc != 4'hF) m_mc = m_mc + 4'h1;
        end
    endtask

    task automatic look(input logic [31:0] ipc, input logic e_busy, input logic e_est, input logic [31:0] e_tgt);
        step(ipc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, e_busy, e_est, e_tgt);
    endtask

    task automatic upd(input logic [31:0] ipc, input logic [31:0] epc, input logic tk,
                       input logic [31:0] etg, input logic ms, input logic e_est, input logic [31:0] e_tgt);
        step(ipc, 1'b1, epc, tk, etg, ms, 1'b0, 1'b0, e_est, e_tgt);
    endtask

    initial begin
        reset_n = 1'b0;
        if_pc = '0; ex_branch = 1'b0; ex_pc = '0; ex_taken = 1'b0;
        ex_target = '0; ex_prediction_miss = 1'b0; flush_req = 1'b0;
        @(posedge clk);
        #1;
        step(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        reset_n = 1'b1;

        // Sweep after reset: updates offered during it must be ignored.
        for (int i = 0; i < 16; i++)
            step(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        look(32'h40, 1'b0, 1'b0, 32'h0);

        // Allocate; same-cycle lookup still sees the old (empty) entry.
        upd(32'h40, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0);
        look(32'h40, 1'b0, 1'b1, 32'h100);

        // 10 -> 01 -> 00, then back up 00 -> 01 -> 10 with a new target.
        upd(32'h40, 32'h40, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100);
        upd(32'h40, 32'h40, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0);
        look(32'h40, 1'b0, 1'b0, 32'h0);
        upd(32'h40, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0);
        upd(32'h40, 32'h40, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0);
        look(32'h40, 1'b0, 1'b1, 32'h200);

        // Upper saturation: 10 -> 11 -> 11 -> 10 -> 01.
        upd(32'h40, 32'h40, 1'b1, 32'h200, 1'b0, 1'b1, 32'h200);
        upd(32'h40, 32'h40, 1'b1, 32'h200, 1'b0, 1'b1, 32'h200);
        upd(32'h40, 32'h40, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200);
        upd(32'h40, 32'h40, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200);
        look(32'h40, 1'b0, 1'b0, 32'h0);
        upd(32'h40, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0);
        look(32'h40, 1'b0, 1'b1, 32'h100);

        // Miss flag without ex_branch is ignored.
        step(32'h40, 1'b0, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100);

        // Aliasing 0x440 onto index 0 evicts 0x40.
        upd(32'h40, 32'h440, 1'b1, 32'h300, 1'b1, 1'b1, 32'h100);
        look(32'h40,  1'b0, 1'b0, 32'h0);
        look(32'h440, 1'b0, 1'b1, 32'h300);

        // Not-taken miss does not allocate.
        upd(32'h80, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        look(32'h80, 1'b0, 1'b0, 32'h0);

        // Flush with a same-cycle update, then re-flush mid-sweep.
        step(32'h440, 1'b1, 32'h440, 1'b1, 32'h500, 1'b1, 1'b1, 1'b0, 1'b1, 32'h300);
        for (int i = 0; i < 22; i++)
            step(32'h440, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, (i == 5), 1'b1, 1'b0, 32'h0);
        look(32'h440, 1'b0, 1'b0, 32'h0);
        look(32'h40,  1'b0, 1'b0, 32'h0);

        // Statistics saturation.
        for (int i = 0; i < 17; i++)
            upd(32'h80, 32'h80, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        look(32'h80, 1'b0, 1'b0, 32'h0);

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Dynamic branch predictor that drives the branch_estimation input of the EX-stage branch resolution logic. It is a direct-mapped table of 2-bit saturating counters with tags and targets:
- IF stage: combinational lookup by fetch PC, giving predicted direction and target.
- EX stage: the table is trained with the resolved outcome (taken, target, misprediction).
- A sweep FSM invalidates the table after reset and on flush request.
- Saturating statistics counters are provided for performance monitoring.

Parameters:
INDEX_BITS, 4, log2 of table entries (ENTRIES = 2**INDEX_BITS).
XLEN, 32, address/data width.
CNT_WIDTH, 32, width of statistics counters.

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
if_pc  input  XLEN  fetch-stage PC to look up
branch_estimation  output  1  predicted taken for if_pc
predicted_target  output  XLEN  predicted target for if_pc (0 when branch_estimation=0)
ex_branch  input  1  EX stage holds a conditional branch (update strobe)
ex_pc  input  XLEN  PC of the EX-stage branch
ex_taken  input  1  resolved direction
ex_target  input  XLEN  resolved target (pc + imm)
ex_prediction_miss  input  1  resolved misprediction flag
flush_req  input  1  request full table invalidation (single-cycle pulse or level)
busy  output  1  invalidation sweep in progress
branch_count  output  CNT_WIDTH  branches resolved since reset
miss_count  output  CNT_WIDTH  mispredictions since reset

Behaviour:
- Index = pc[INDEX_BITS+1:2]; tag = pc[XLEN-1:INDEX_BITS+2]. Each entry holds valid, tag, target, and ctr[1:0].
- Table arrays have no reset and are RAM-inferable. Only valid bits are cleared, by the sweep.
- FSM states:
  - CLEAR: writes valid=0 at sweep index clr_idx, then increments clr_idx. After the write at ENTRIES-1, moves to IDLE. One entry per cycle, so a sweep lasts exactly ENTRIES cycles.
  - IDLE: normal operation.
- Reset (reset_n=0, asynchronous) sets:
  - state=CLEAR, clr_idx=0, branch_count=0, miss_count=0.
  - Outputs: busy=1, branch_estimation=0, predicted_target=0.
- busy = (state==CLEAR). While busy, branch_estimation=0 and predicted_target=0, and ex_branch updates are ignored (not written, not counted).
- flush_req in IDLE: state=CLEAR with clr_idx=0 at the next edge. Any update in that same cycle is dropped.
- flush_req in CLEAR: clr_idx restarts at 0 and the sweep runs a full ENTRIES cycles again.
- Lookup (IDLE) is combinational with zero latency:
  - hit = valid && tag match.
  - branch_estimation = hit && ctr[1].
  - predicted_target = stored target when branch_estimation=1, else 0.
- Update (IDLE, ex_branch=1) writes at the same rising edge:
  - Hit: ctr saturating +1 if ex_taken, else saturating -1 (bounds 0..3). target is replaced with ex_target when ex_taken.
  - Miss and ex_taken: allocate the entry with valid=1, new tag, target=ex_target, ctr=2'b10. This overwrites any conflicting entry.
  - Miss and not taken: no write.
- Same-cycle lookup and update to the same index: the lookup returns pre-update contents (no bypass). The new value is visible from the next cycle.
- Statistics (IDLE only):
  - branch_count increments on ex_branch.
  - miss_count increments on ex_branch && ex_prediction_miss.
  - Both saturate at all-ones and are not cleared by flush_req.
- ex_prediction_miss with ex_branch=0 is ignored.

Decomposition:
- Shared package (branch.vh additions): 2-bit counter encodings (STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11) and FSM state codes (BP_CLEAR, BP_IDLE).
- One sub-module: bp_sat_counter, a combinational 2-bit saturating increment/decrement. Table storage and FSM stay in the top module.

Test Plan:
- Reset then 16 idle cycles (INDEX_BITS=4) -> busy=1 for exactly 16 cycles, then 0. branch_estimation=0 throughout. Both counters 0.
- Taken branch at ex_pc=0x0000_0040, ex_target=0x0000_0100 -> next cycle if_pc=0x40 gives branch_estimation=1, predicted_target=0x100, branch_count=1.
- Same PC resolved not-taken twice -> ctr goes 10->01->00. Lookup gives estimation 0 after the first update, and it stays 0. Then two taken updates restore estimation 1 (00->01->10).
- Aliasing: train 0x40 taken, then 0x440 taken (same index, different tag) -> if_pc=0x40 misses (estimation 0), if_pc=0x440 hits with its own target.
- flush_req pulse while a trained entry exists and with ex_branch=1 in the same cycle -> update dropped, counters unchanged, busy=1 for 16 cycles, afterwards 0x40 predicts not-taken.
- Saturation with CNT_WIDTH=4: 17 mispredicted branches -> branch_count=miss_count=4'hF. Same-index same-cycle lookup/update returns old prediction, new one next cycle.
